wb_register_file: RTL

WB_REGISTER_FILE -- requirements
Module: wb_register_file

---
 rtl/wb_register_file_pkg.sv | 24 ++
 rtl/wb_scoreboard.sv | 85 ++++++++
 rtl/wb_register_file.sv | 98 +++++++++
 3 files changed

// File: rtl/wb_register_file_pkg.sv
// Shared definitions for the write-back register file: wb_bus field layout,
// control bit indices, default sizes and pending-counter width.
package wb_register_file_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_NUM_REGS = 16;
  localparam int WB_ADDR_W   = 4;
  localparam int WB_CNT_W    = 2;
  localparam int WB_CNT_MAX  = (1 << WB_CNT_W) - 1;
  localparam int WB_BUS_W    = 76;

  // wb_bus field offsets (LSB of each field)
  localparam int CTRL_LSB      = 72;
  localparam int RES_ADDR_LSB  = 68;
  localparam int BASE_ADDR_LSB = 64;
  localparam int BASE_DATA_LSB = 32;
  localparam int RES_DATA_LSB  = 0;
  localparam int CTRL_W        = 4;

  // control bit indices within the control field
  localparam int CTRL_RES_WE  = 3;
  localparam int CTRL_BASE_WE = 2;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters. Decode reserves destinations through
// the two issue ports, write-back retires them. Produces issue_ready and the
// read-hazard stall. Optional macro: WB_BYPASS_EN (same-cycle retires also
// clear the hazard, because the read data is forwarded from the write port).
module wb_scoreboard
  import wb_register_file_pkg::*;
#(
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid0,
  input  logic                 issue_valid1,
  input  logic [WB_ADDR_W-1:0] issue_addr0,
  input  logic [WB_ADDR_W-1:0] issue_addr1,
  input  logic                 ret_en0,
  input  logic                 ret_en1,
  input  logic [WB_ADDR_W-1:0] ret_addr0,
  input  logic [WB_ADDR_W-1:0] ret_addr1,
  input  logic [WB_ADDR_W-1:0] rd_addr_a,
  input  logic [WB_ADDR_W-1:0] rd_addr_b,
  input  logic [WB_ADDR_W-1:0] rd_addr_c,
  output logic                 issue_ready,
  output logic                 stall
);

  logic [WB_CNT_W-1:0] cnt      [NUM_REGS];
  logic [WB_CNT_W-1:0] cnt_next [NUM_REGS];
  logic [1:0]          n_iss    [NUM_REGS];
  logic [1:0]          n_ret    [NUM_REGS];

  // Clamp (up - down) into the counter range 0..WB_CNT_MAX.
  function automatic logic [WB_CNT_W-1:0] sat_cnt(input logic [3:0] up,
                                                  input logic [3:0] down);
    if (down >= up)
      return '0;
    else if ((up - down) > 4'(WB_CNT_MAX))
      return WB_CNT_W'(WB_CNT_MAX);
    else
      return WB_CNT_W'(up - down);
  endfunction

  // A read address is hazardous while writes to it are still outstanding.
  function automatic logic busy(input logic [WB_ADDR_W-1:0] a);
`ifdef WB_BYPASS_EN
    return sat_cnt({2'b00, cnt[a]}, {2'b00, n_ret[a]}) != '0;
`else
    return cnt[a] != '0;
`endif
  endfunction

  // Per-register issue/retire tallies; refuse both issues if any target would overflow.
  always_comb begin
    issue_ready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      n_iss[i] = {1'b0, issue_valid0 && (issue_addr0 == WB_ADDR_W'(i))}
               + {1'b0, issue_valid1 && (issue_addr1 == WB_ADDR_W'(i))};
      n_ret[i] = {1'b0, ret_en0 && (ret_addr0 == WB_ADDR_W'(i))}
               + {1'b0, ret_en1 && (ret_addr1 == WB_ADDR_W'(i))};
      if (({2'b00, cnt[i]} + {2'b00, n_iss[i]}) > ({2'b00, n_ret[i]} + 4'(WB_CNT_MAX)))
        issue_ready = 1'b0;
    end
  end

  // Next count = current + accepted issues - retires, clamped.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_next[i] = sat_cnt({2'b00, cnt[i]} + {2'b00, (issue_ready ? n_iss[i] : 2'b00)},
                            {2'b00, n_ret[i]});
    end
  end

  // Counter state; reset discards all reservations.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset)
        cnt[i] <= '0;
      else
        cnt[i] <= cnt_next[i];
    end
  end

  assign stall = busy(rd_addr_a) | busy(rd_addr_b) | busy(rd_addr_c);

endmodule

// File: rtl/wb_register_file.sv
// Write-back register file: two write ports fed by the MEM/WB bus (result and
// base update, result wins on collision), three combinational read ports and
// a pending-write scoreboard. Optional macro: WB_BYPASS_EN forwards same-cycle
// write data to the read ports.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WB_BUS_W-1:0]  wb_bus,
  input  logic [WB_ADDR_W-1:0] rd_addr_a,
  input  logic [WB_ADDR_W-1:0] rd_addr_b,
  input  logic [WB_ADDR_W-1:0] rd_addr_c,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic [DATA_W-1:0]    rd_data_c,
  input  logic                 issue_valid0,
  input  logic                 issue_valid1,
  input  logic [WB_ADDR_W-1:0] issue_addr0,
  input  logic [WB_ADDR_W-1:0] issue_addr1,
  output logic                 issue_ready,
  output logic                 stall
);

  logic [CTRL_W-1:0]    ctrl;
  logic                 res_we;
  logic                 base_we;
  logic [WB_ADDR_W-1:0] res_addr;
  logic [WB_ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0]    res_data;
  logic [DATA_W-1:0]    base_data;
  logic                 unused_ctrl;
  logic [DATA_W-1:0]    regs [NUM_REGS];

  assign ctrl        = wb_bus[CTRL_LSB +: CTRL_W];
  assign res_we      = ctrl[CTRL_RES_WE];
  assign base_we     = ctrl[CTRL_BASE_WE];
  assign unused_ctrl = ^ctrl[1:0];
  assign res_addr    = wb_bus[RES_ADDR_LSB +: WB_ADDR_W];
  assign base_addr   = wb_bus[BASE_ADDR_LSB +: WB_ADDR_W];
  assign res_data    = wb_bus[RES_DATA_LSB +: DATA_W];
  assign base_data   = wb_bus[BASE_DATA_LSB +: DATA_W];

  // Read one port: array value, or the in-flight write when forwarding is built in.
  function automatic logic [DATA_W-1:0] rd_port(input logic [WB_ADDR_W-1:0] a);
`ifdef WB_BYPASS_EN
    if (res_we && (res_addr == a))
      return res_data;
    else if (base_we && (base_addr == a))
      return base_data;
`endif
    return regs[a];
  endfunction

  // Register array; the result write is issued last so it wins a collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      if (base_we)
        regs[base_addr] <= base_data;
      if (res_we)
        regs[res_addr] <= res_data;
    end
  end

  // Zero-latency read ports.
  always_comb begin
    rd_data_a = rd_port(rd_addr_a);
    rd_data_b = rd_port(rd_addr_b);
    rd_data_c = rd_port(rd_addr_c);
  end

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .issue_valid0 (issue_valid0),
    .issue_valid1 (issue_valid1),
    .issue_addr0  (issue_addr0),
    .issue_addr1  (issue_addr1),
    .ret_en0      (res_we),
    .ret_en1      (base_we),
    .ret_addr0    (res_addr),
    .ret_addr1    (base_addr),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_addr_c    (rd_addr_c),
    .issue_ready  (issue_ready),
    .stall        (stall)
  );

endmodule
